// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
//   Shared VGA definitions for the square drawing pipeline: screen geometry,
//   the pixel record carried between stages, and the 3-bit colour palette.
// ---------------------------------------------------------------------------
package vga_pkg;

   localparam int unsigned SCREEN_W = 160;
   localparam int unsigned SCREEN_H = 120;

   typedef struct packed {
      logic [8:0] x;
      logic [7:0] y;
      logic [2:0] colour;
   } pixel_t;

   localparam logic [2:0] BLACK   = 3'd0;
   localparam logic [2:0] BLUE    = 3'd1;
   localparam logic [2:0] GREEN   = 3'd2;
   localparam logic [2:0] CYAN    = 3'd3;
   localparam logic [2:0] RED     = 3'd4;
   localparam logic [2:0] MAGENTA = 3'd5;
   localparam logic [2:0] YELLOW  = 3'd6;
   localparam logic [2:0] WHITE   = 3'd7;

endpackage

// File: rtl/plot_fifo.sv
// ---------------------------------------------------------------------------
// plot_fifo
//   Small synchronous FIFO of pixel records between the translate stage and
//   the shared VGA port. Pointers carry one extra wrap bit so full and empty
//   are distinguished without a separate counter.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (pointers only)
//   push, wdata  write strobe and pixel; ignored when full unless popping
//   pop          read strobe; advances the head (ignored when empty)
//   rdata        current head pixel (valid while !empty)
//   empty, full  occupancy flags
// ---------------------------------------------------------------------------
module plot_fifo
   import vga_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   push,
   input  pixel_t wdata,
   input  logic   pop,
   output pixel_t rdata,
   output logic   empty,
   output logic   full
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   pixel_t      mem [DEPTH];

   logic do_push;
   logic do_pop;

   // A full FIFO still accepts a write when the head leaves in the same
   // cycle: the freed slot is exactly the one the write pointer targets.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: the storage array has no reset; the pointers alone define which
   // entries are meaningful, and an unreset array maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/square_plot_placer.sv
// ---------------------------------------------------------------------------
// square_plot_placer
//   Sits between the square filler and the shared VGA adapter. Each local
//   pixel (origin 0,0) is offset by a latched screen origin, clipped to the
//   visible screen and queued; the queue drains to the adapter only on the
//   cycles the arbiter grants the port, so the filler never stalls.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   origin_x/origin_y/load_origin square top-left, latched when load_origin
//   in_x/in_y/in_colour/in_plot   local pixel stream from the filler
//   in_done                       filler finished (level)
//   gnt / req                     arbiter grant / FIFO non-empty request
//   vga_x/vga_y/vga_colour/vga_plot  registered pixel to the adapter
//   done                          every pixel of the square delivered
//   clip_count / overflow         saturating clip count, sticky drop flag
//   clear_status                  synchronous clear of the two status fields
// ---------------------------------------------------------------------------
module square_plot_placer #(
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned SCREEN_W = vga_pkg::SCREEN_W,
   parameter int unsigned SCREEN_H = vga_pkg::SCREEN_H
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [8:0] origin_x,
   input  logic [7:0] origin_y,
   input  logic       load_origin,
   input  logic [8:0] in_x,
   input  logic [7:0] in_y,
   input  logic [2:0] in_colour,
   input  logic       in_plot,
   input  logic       in_done,
   input  logic       gnt,
   output logic       req,
   output logic [8:0] vga_x,
   output logic [7:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot,
   output logic       done,
   output logic [7:0] clip_count,
   output logic       overflow,
   input  logic       clear_status
);

   logic [8:0]       org_x;
   logic [7:0]       org_y;
   logic [9:0]       sx;
   logic [8:0]       sy;
   logic             on_screen;
   logic             s1_valid;
   vga_pkg::pixel_t  s1_pixel;
   vga_pkg::pixel_t  head;
   logic             fifo_empty;
   logic             fifo_full;
   logic             pop;

   // Widened sums: a large origin plus a large offset must clip, not wrap
   // back onto the visible screen.
   assign sx        = {1'b0, org_x} + {1'b0, in_x};
   assign sy        = {1'b0, org_y} + {1'b0, in_y};
   assign on_screen = (sx < 10'(SCREEN_W)) && (sy < 9'(SCREEN_H));

   assign req = !fifo_empty;
   assign pop = req && gnt;

   // Gated by rst_n so done reads 0 throughout reset even with in_done high.
   assign done = rst_n && in_done && !s1_valid && fifo_empty && !vga_plot;

   // The translate stage reads org_x/org_y before this edge updates them,
   // so a pixel arriving with load_origin still uses the previous origin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         org_x    <= '0;
         org_y    <= '0;
         s1_valid <= 1'b0;
         s1_pixel <= '0;
      end else begin
         if (load_origin) begin
            org_x <= origin_x;
            org_y <= origin_y;
         end
         s1_valid <= in_plot && on_screen;
         if (in_plot && on_screen) begin
            s1_pixel <= '{x: sx[8:0], y: sy[7:0], colour: in_colour};
         end
      end
   end

   plot_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (s1_valid),
      .wdata (s1_pixel),
      .pop   (pop),
      .rdata (head),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         vga_plot   <= 1'b0;
      end else begin
         vga_plot <= pop;
         if (pop) begin
            vga_x      <= head.x;
            vga_y      <= head.y;
            vga_colour <= head.colour;
         end
      end
   end

   // Clear has priority over a same-cycle increment or drop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clip_count <= '0;
         overflow   <= 1'b0;
      end else if (clear_status) begin
         clip_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (in_plot && !on_screen && (clip_count != 8'hFF)) begin
            clip_count <= clip_count + 8'd1;
         end
         if (s1_valid && fifo_full && !pop) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_square_plot_placer.sv
// ---------------------------------------------------------------------------
// tb_square_plot_placer
//   Self-checking bench: a table of single-pixel translate/clip vectors,
//   then multi-cycle sequences (full squares, stalled grant, toggling grant,
//   same-cycle origin load, asynchronous reset). Expected pixels go into a
//   scoreboard queue when driven and are compared as vga_plot strobes appear.
// ---------------------------------------------------------------------------
module tb_square_plot_placer;
   import vga_pkg::*;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [8:0] origin_x = '0;
   logic [7:0] origin_y = '0;
   logic       load_origin = 1'b0;
   logic [8:0] in_x = '0;
   logic [7:0] in_y = '0;
   logic [2:0] in_colour = '0;
   logic       in_plot = 1'b0;
   logic       in_done = 1'b1;
   logic       gnt = 1'b0;
   logic       req;
   logic [8:0] vga_x;
   logic [7:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;
   logic       done;
   logic [7:0] clip_count;
   logic       overflow;
   logic       clear_status = 1'b0;

   always #5 clk = ~clk;

   square_plot_placer #(
      .DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .origin_x     (origin_x),
      .origin_y     (origin_y),
      .load_origin  (load_origin),
      .in_x         (in_x),
      .in_y         (in_y),
      .in_colour    (in_colour),
      .in_plot      (in_plot),
      .in_done      (in_done),
      .gnt          (gnt),
      .req          (req),
      .vga_x        (vga_x),
      .vga_y        (vga_y),
      .vga_colour   (vga_colour),
      .vga_plot     (vga_plot),
      .done         (done),
      .clip_count   (clip_count),
      .overflow     (overflow),
      .clear_status (clear_status)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   typedef struct {
      int x;
      int y;
      int c;
   } exp_t;

   exp_t sb_q[$];

   int org_x = 0;
   int org_y = 0;
   int exp_clip = 0;
   int strobes = 0;
   int cyc = 0;
   int first_drive_cyc = -1;
   int first_plot_cyc = -1;
   bit track_latency = 1'b0;
   bit toggle_mode = 1'b0;
   bit prev_plot = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (vga_plot) begin
         strobes++;
         if (track_latency && first_plot_cyc < 0) first_plot_cyc = cyc;
         if (toggle_mode) check("no_back_to_back", int'(prev_plot), 0);
         if (sb_q.size() == 0) begin
            check("unexpected_strobe", 1, 0);
         end else begin
            e = sb_q.pop_front();
            check("strobe_x", int'(vga_x), e.x);
            check("strobe_y", int'(vga_y), e.y);
            check("strobe_colour", int'(vga_colour), e.c);
         end
      end
      prev_plot = vga_plot;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (toggle_mode) gnt = !gnt;
   endtask

   function automatic int colour_of(input int x, input int y);
      return (x * 3 + y) % 8;
   endfunction

   task automatic drive_pixel(input int x, input int y, input int c, input bit auto_exp);
      exp_t e;
      in_x      = 9'(x);
      in_y      = 8'(y);
      in_colour = 3'(c);
      in_plot   = 1'b1;
      if (auto_exp) begin
         if ((org_x + x) < 160 && (org_y + y) < 120) begin
            e.x = org_x + x;
            e.y = org_y + y;
            e.c = c;
            sb_q.push_back(e);
         end else if (exp_clip < 255) begin
            exp_clip++;
         end
      end
      tick();
      in_plot = 1'b0;
   endtask

   // Filler order: y is the inner loop.
   task automatic drive_square(input int w, input int h, input int gap, input bit auto_exp);
      for (int x = 0; x < w; x++) begin
         for (int y = 0; y < h; y++) begin
            drive_pixel(x, y, colour_of(x, y), auto_exp);
            repeat (gap) tick();
         end
      end
   endtask

   task automatic set_origin(input int ox, input int oy);
      origin_x    = 9'(ox);
      origin_y    = 8'(oy);
      load_origin = 1'b1;
      tick();
      load_origin = 1'b0;
      org_x = ox;
      org_y = oy;
   endtask

   task automatic clear_stat();
      clear_status = 1'b1;
      tick();
      clear_status = 1'b0;
      exp_clip = 0;
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      repeat (2) tick();
      check(name, sb_q.size(), 0);
   endtask

   function automatic void push_exp(input int x, input int y, input int c);
      exp_t e;
      e.x = x;
      e.y = y;
      e.c = c;
      sb_q.push_back(e);
   endfunction

   typedef struct {
      int ox;
      int oy;
      int lx;
      int ly;
      int colour;
      bit exp_plot;
      int ex;
      int ey;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int base;
      int tab_clip;

      vecs[0] = '{ox: 0,   oy: 0,   lx: 0,   ly: 0,  colour: 7, exp_plot: 1, ex: 0,   ey: 0};
      vecs[1] = '{ox: 100, oy: 100, lx: 59,  ly: 19, colour: 4, exp_plot: 1, ex: 159, ey: 119};
      vecs[2] = '{ox: 100, oy: 100, lx: 60,  ly: 19, colour: 2, exp_plot: 0, ex: 0,   ey: 0};
      vecs[3] = '{ox: 100, oy: 100, lx: 59,  ly: 20, colour: 2, exp_plot: 0, ex: 0,   ey: 0};
      vecs[4] = '{ox: 400, oy: 0,   lx: 112, ly: 0,  colour: 1, exp_plot: 0, ex: 0,   ey: 0};
      vecs[5] = '{ox: 0,   oy: 200, lx: 0,   ly: 56, colour: 1, exp_plot: 0, ex: 0,   ey: 0};
      vecs[6] = '{ox: 10,  oy: 20,  lx: 5,   ly: 6,  colour: 5, exp_plot: 1, ex: 15,  ey: 26};
      vecs[7] = '{ox: 0,   oy: 0,   lx: 159, ly: 0,  colour: 3, exp_plot: 1, ex: 159, ey: 0};

      // ---- reset state (in_done held high: done must still read 0) ----
      #12;
      check("rst_req", int'(req), 0);
      check("rst_plot", int'(vga_plot), 0);
      check("rst_done", int'(done), 0);
      check("rst_clip", int'(clip_count), 0);
      check("rst_overflow", int'(overflow), 0);
      check("rst_vga_x", int'(vga_x), 0);
      check("rst_vga_y", int'(vga_y), 0);
      check("rst_vga_colour", int'(vga_colour), 0);
      rst_n   = 1'b1;
      in_done = 1'b0;
      gnt     = 1'b1;
      tick();

      // ---- table: translate and clip boundaries ----
      tab_clip = 0;
      foreach (vecs[i]) begin
         set_origin(vecs[i].ox, vecs[i].oy);
         if (vecs[i].exp_plot) push_exp(vecs[i].ex, vecs[i].ey, vecs[i].colour);
         else tab_clip++;
         drive_pixel(vecs[i].lx, vecs[i].ly, vecs[i].colour, 1'b0);
         wait_drain($sformatf("vec%0d_delivered", i));
         check($sformatf("vec%0d_clip", i), int'(clip_count), tab_clip);
      end

      // ---- clip_count saturation, then clear beats increment ----
      clear_stat();
      check("clear_clip", int'(clip_count), 0);
      set_origin(0, 0);
      for (int i = 0; i < 260; i++) drive_pixel(200, 0, 0, 1'b1);
      tick();
      check("clip_saturate", int'(clip_count), 255);
      clear_status = 1'b1;
      in_x    = 9'd200;
      in_plot = 1'b1;
      tick();
      clear_status = 1'b0;
      in_plot      = 1'b0;
      exp_clip     = 0;
      check("clear_wins", int'(clip_count), 0);

      // ---- 7x8 square at (20,30), gnt held ----
      set_origin(20, 30);
      track_latency   = 1'b1;
      first_drive_cyc = cyc;
      first_plot_cyc  = -1;
      base = strobes;
      drive_square(7, 8, 0, 1'b1);
      wait_drain("sq1_delivered");
      track_latency = 1'b0;
      check("sq1_latency", first_plot_cyc - first_drive_cyc, 3);
      check("sq1_strobes", strobes - base, 56);
      check("sq1_last_x", int'(vga_x), 26);
      check("sq1_last_y", int'(vga_y), 37);
      in_done = 1'b1;
      tick();
      check("sq1_done", int'(done), 1);
      check("sq1_clip", int'(clip_count), 0);
      check("sq1_overflow", int'(overflow), 0);
      in_done = 1'b0;
      #1;
      check("sq1_done_falls", int'(done), 0);

      // ---- square at (155,115): edge clipping ----
      clear_stat();
      set_origin(155, 115);
      base = strobes;
      drive_square(7, 8, 0, 1'b1);
      wait_drain("sq2_delivered");
      check("sq2_strobes", strobes - base, 25);
      check("sq2_clip", int'(clip_count), 31);
      check("sq2_clip_model", int'(clip_count), exp_clip);
      in_done = 1'b1;
      tick();
      check("sq2_done", int'(done), 1);
      in_done = 1'b0;

      // ---- grant withheld: FIFO fills, later pixels dropped ----
      clear_stat();
      set_origin(0, 0);
      gnt  = 1'b0;
      base = strobes;
      drive_square(7, 8, 0, 1'b0);
      repeat (4) tick();
      check("stall_req", int'(req), 1);
      check("stall_overflow", int'(overflow), 1);
      check("stall_no_strobe", strobes - base, 0);
      for (int y = 0; y < 8; y++) push_exp(0, y, colour_of(0, y));
      gnt = 1'b1;
      wait_drain("stall_delivered");
      repeat (4) tick();
      check("stall_strobes", strobes - base, 8);
      in_done = 1'b1;
      tick();
      check("stall_done", int'(done), 1);
      in_done = 1'b0;
      clear_stat();
      check("clear_overflow", int'(overflow), 0);

      // ---- toggling grant, filler every other cycle ----
      base        = strobes;
      gnt         = 1'b0;
      toggle_mode = 1'b1;
      drive_square(7, 8, 1, 1'b1);
      wait_drain("toggle_delivered");
      toggle_mode = 1'b0;
      gnt         = 1'b1;
      check("toggle_strobes", strobes - base, 56);
      check("toggle_overflow", int'(overflow), 0);

      // ---- origin load in the same cycle as a pixel ----
      origin_x    = 9'd50;
      origin_y    = 8'd50;
      load_origin = 1'b1;
      drive_pixel(0, 0, 6, 1'b1);
      load_origin = 1'b0;
      org_x = 50;
      org_y = 50;
      drive_pixel(0, 1, 5, 1'b1);
      drive_pixel(1, 0, 4, 1'b1);
      wait_drain("origin_same_cycle");

      // ---- asynchronous reset with buffered pixels ----
      set_origin(0, 0);
      gnt     = 1'b0;
      in_done = 1'b1;
      for (int y = 0; y < 5; y++) drive_pixel(1, y, 2, 1'b0);
      drive_pixel(200, 0, 2, 1'b0);
      repeat (3) tick();
      check("pre_rst_req", int'(req), 1);
      check("pre_rst_clip", int'(clip_count), 1);
      gnt = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_plot", int'(vga_plot), 0);
      check("arst_req", int'(req), 0);
      check("arst_done", int'(done), 0);
      check("arst_clip", int'(clip_count), 0);
      check("arst_overflow", int'(overflow), 0);
      tick();
      rst_n = 1'b1;
      org_x = 0;
      org_y = 0;
      exp_clip = 0;
      sb_q.delete();
      base = strobes;
      repeat (12) tick();
      check("post_rst_no_stale", strobes - base, 0);
      check("post_rst_req", int'(req), 0);
      check("post_rst_done", int'(done), 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/square_plot_placer.md
Name: square_plot_placer

Overview:
- Downstream stage of the square filler.
- Takes the filler's local pixel stream (vga_x/vga_y/vga_colour/vga_plot, origin 0,0) and translates each pixel by a latched screen origin.
- Clips pixels to the 160x120 VGA screen and buffers them in a small FIFO.
- Drains the FIFO to the shared VGA adapter port only when the game master's arbiter grants access, so the filler never has to stall.

Parameters:
DEPTH, 8, FIFO entries (power of two, >= 4)
SCREEN_W, 160, visible columns; x >= SCREEN_W is clipped
SCREEN_H, 120, visible rows; y >= SCREEN_H is clipped

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
origin_x  in  9  screen x of square's top-left pixel
origin_y  in  8  screen y of square's top-left pixel
load_origin  in  1  latch origin_x/origin_y this cycle
in_x  in  9  local pixel x from filler
in_y  in  8  local pixel y from filler
in_colour  in  3  pixel colour from filler
in_plot  in  1  pixel valid strobe from filler
in_done  in  1  filler done level
gnt  in  1  VGA port granted this cycle
req  out  1  FIFO non-empty, requesting VGA port
vga_x  out  9  translated pixel x to adapter
vga_y  out  8  translated pixel y to adapter
vga_colour  out  3  pixel colour to adapter
vga_plot  out  1  one-cycle plot strobe to adapter
done  out  1  all pixels of current square delivered
clip_count  out  8  pixels dropped by clipping, saturating
overflow  out  1  sticky: pixel dropped because FIFO full
clear_status  in  1  sync clear of clip_count and overflow

Behaviour:
- Reset (async, rst_n=0) values: origin regs=0; FIFO empty, pointers=0; stage-1 valid=0; vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, req=0, done=0, clip_count=0, overflow=0. Reset mid-operation discards all buffered pixels immediately.
- Origin: load_origin captures origin on the rising edge. A pixel arriving in the same cycle uses the old origin; the new origin applies from the next cycle.
- Stage 1 (translate, 1 cycle): sx = origin_x + in_x computed 10-bit; sy = origin_y + in_y computed 9-bit, so there is no wrap. If in_plot && sx < SCREEN_W && sy < SCREEN_H, register {sx[8:0], sy[7:0], in_colour} with s1_valid=1. If in_plot and clipped, s1_valid=0 and clip_count increments, saturating at 255.
- Stage 2 (FIFO, sub-module): push = s1_valid. Pop = req && gnt.
  - Full with push and pop in the same cycle: both succeed, count unchanged.
  - Full with push and no pop: pixel dropped, overflow set.
  - Empty: pop impossible, since req=0.
- Output register: on pop, vga_x/vga_y/vga_colour load the FIFO head and vga_plot=1 the next cycle. Otherwise vga_plot=0 and the data outputs hold their last value.
- Latency: in_plot in cycle N, FIFO entry visible (req=1) in N+2; with gnt high, vga_plot=1 in N+3. One pixel per cycle sustained under continuous gnt.
- req = FIFO non-empty. gnt while req=0 is ignored. gnt may drop at any cycle; draining pauses with no loss.
- done = in_done && !s1_valid && FIFO empty && !vga_plot. It deasserts combinationally when in_done falls (filler restarted).
- clear_status zeroes clip_count and overflow next cycle. If clear and increment happen in the same cycle, clear wins.
- clip_count/overflow are informational only; they never block the pipeline.

Decomposition:
- Package vga_pkg:
  - SCREEN_W/SCREEN_H constants.
  - typedef struct packed pixel_t {logic [8:0] x; logic [7:0] y; logic [2:0] colour;}.
  - Colour constants (BLACK..WHITE 3'd0..3'd7).
- Sub-module plot_fifo:
  - Parameter DEPTH; ports: clk, rst_n, push, pixel_t wdata, pop, pixel_t rdata, empty, full.
  - Pointer-based, one extra pointer bit for full/empty detection.
- Top level holds origin regs, translate stage, output register, status counters.

Test Plan:
- Origin (20,30), gnt held 1, filler draws 7x8 square -> 56 vga_plot strobes, first (20,30) three cycles after first in_plot, last (26,37), done=1 after last strobe, clip_count=0, overflow=0.
- Origin (155,115), gnt=1 -> pixels with x<=159 and y<=119 delivered (5x5=25 strobes), clip_count=31, done asserts.
- gnt=0 throughout a 56-pixel square with DEPTH=8 -> req=1, FIFO holds first 8 pixels, overflow=1. Then gnt=1 -> exactly 8 strobes (0,0)..(0,7) at origin 0, then done=1.
- gnt toggling 1/0 every cycle, DEPTH=8, filler plots every other cycle -> all 56 pixels delivered in order, no overflow, never two strobes in consecutive cycles while gnt=0.
- load_origin to (50,50) in the same cycle as first in_plot at old origin (0,0) -> first pixel out at (0,0), following pixels offset by (50,50).
- rst_n pulsed low while FIFO holds 5 entries -> vga_plot, req, done, clip_count, overflow all 0 immediately (asynchronously), no stale pixels emitted after release.
